// File: rtl/mini_alu_core_if.sv
// mini_alu_core_if: instruction-ROM fetch bus and board outputs of mini_alu_core.
// Signals:
//   oIP          fetch address, driven by the core
//   iInstruction ROM data for oIP, valid in the same cycle
//   oLed         LED register, driven by the core
//   oFault       sticky fault flag, driven by the core
// Modports: master = core side, slave = ROM/board side.
interface mini_alu_core_if #(
    parameter int unsigned IP_WIDTH  = 16,
    parameter int unsigned LED_WIDTH = 8
);
    logic [IP_WIDTH-1:0]  oIP;
    logic [27:0]          iInstruction;
    logic [LED_WIDTH-1:0] oLed;
    logic                 oFault;

    modport master (output oIP, output oLed, output oFault, input iInstruction);
    modport slave  (input oIP, input oLed, input oFault, output iInstruction);
endinterface

// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage (fetch/execute) core running 28-bit instructions from
// an asynchronous ROM against an internal register file, with equality/less-equal
// branches, shifts, CALL/RET on a bounded return stack and an optional multiplier.
// Optional feature: define MINIALU_MUL_EN to implement op 7 (MUL); otherwise op 7
// is illegal and no multiplier is built.
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous, active-high reset
//   bus    mini_alu_core_if.master (oIP, iInstruction, oLed, oFault)
module mini_alu_core #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned REG_COUNT   = 256,
    parameter int unsigned IP_WIDTH    = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned LED_WIDTH   = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    mini_alu_core_if.master bus
);
    localparam int unsigned AddrWidth  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned RegDepth   = 1 << AddrWidth;
    localparam int unsigned SpWidth    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned StackSlots = 1 << SpWidth;

    localparam logic [3:0] opNop  = 4'h0;
    localparam logic [3:0] opLed  = 4'h1;
    localparam logic [3:0] opBle  = 4'h2;
    localparam logic [3:0] opSto  = 4'h3;
    localparam logic [3:0] opAdd  = 4'h4;
    localparam logic [3:0] opJmp  = 4'h5;
    localparam logic [3:0] opSub  = 4'h6;
    localparam logic [3:0] opMul  = 4'h7;
    localparam logic [3:0] opShl  = 4'h8;
    localparam logic [3:0] opShr  = 4'h9;
    localparam logic [3:0] opBeq  = 4'hA;
    localparam logic [3:0] opCall = 4'hB;
    localparam logic [3:0] opRet  = 4'hC;

    logic [IP_WIDTH-1:0]   ip;
    logic [IP_WIDTH-1:0]   irAddr;
    logic [27:0]           ir;
    logic [DATA_WIDTH-1:0] regFile [RegDepth];
    logic [IP_WIDTH-1:0]   retStack [StackSlots];
    logic [SpWidth-1:0]    sp;
    logic [LED_WIDTH-1:0]  led;
    logic                  fault;

    // Instruction fields and operand reads of the instruction in execute
    logic [3:0]            op;
    logic [7:0]            dest;
    logic [7:0]            src1;
    logic [7:0]            src0;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs0;
    logic [DATA_WIDTH-1:0] imm;

    assign op   = ir[27:24];
    assign dest = ir[23:16];
    assign src1 = ir[15:8];
    assign src0 = ir[7:0];
    assign rs1  = regFile[src1[AddrWidth-1:0]];
    assign rs0  = regFile[src0[AddrWidth-1:0]];
    assign imm  = DATA_WIDTH'({src1, src0});

    // Execute decode
    logic                  regWe;
    logic [DATA_WIDTH-1:0] regWdata;
    logic                  ledWe;
    logic                  branch;
    logic [IP_WIDTH-1:0]   target;
    logic                  push;
    logic                  pop;
    logic                  faultSet;

    always_comb begin
        regWe    = 1'b0;
        regWdata = '0;
        ledWe    = 1'b0;
        branch   = 1'b0;
        target   = IP_WIDTH'(dest);
        push     = 1'b0;
        pop      = 1'b0;
        faultSet = 1'b0;
        case (op)
            opNop: ;
            opLed: ledWe = 1'b1;
            opBle: branch = (rs1 <= rs0);
            opSto: begin
                regWe    = 1'b1;
                regWdata = imm;
            end
            opAdd: begin
                regWe    = 1'b1;
                regWdata = rs1 + rs0;
            end
            opJmp: branch = 1'b1;
            opSub: begin
                regWe    = 1'b1;
                regWdata = rs1 - rs0;
            end
            opMul: begin
`ifdef MINIALU_MUL_EN
                regWe    = 1'b1;
                regWdata = rs1 * rs0;
`else
                faultSet = 1'b1;
`endif
            end
            // Shift amounts >= DATA_WIDTH naturally shift everything out to 0
            opShl: begin
                regWe    = 1'b1;
                regWdata = rs1 << rs0;
            end
            opShr: begin
                regWe    = 1'b1;
                regWdata = rs1 >> rs0;
            end
            opBeq: branch = (rs1 == rs0);
            // Full stack: no push and no branch, execution falls through
            opCall: begin
                if (sp == SpWidth'(STACK_DEPTH)) begin
                    faultSet = 1'b1;
                end else begin
                    push   = 1'b1;
                    branch = 1'b1;
                end
            end
            opRet: begin
                if (sp == '0) begin
                    faultSet = 1'b1;
                end else begin
                    pop    = 1'b1;
                    branch = 1'b1;
                    target = retStack[sp - SpWidth'(1)];
                end
            end
            default: faultSet = 1'b1;
        endcase
    end

    // Fetch/execute pipeline, LED, stack pointer and fault flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ip     <= '0;
            irAddr <= '0;
            ir     <= '0;
            sp     <= '0;
            led    <= '0;
            fault  <= 1'b0;
        end else begin
            irAddr <= ip;
            if (branch) begin
                // Squash the sequentially fetched instruction
                ip <= target;
                ir <= '0;
            end else begin
                ip <= ip + IP_WIDTH'(1);
                ir <= bus.iInstruction;
            end
            if (ledWe) begin
                led <= rs1[LED_WIDTH-1:0];
            end
            if (push) begin
                sp <= sp + SpWidth'(1);
            end else if (pop) begin
                sp <= sp - SpWidth'(1);
            end
            if (faultSet) begin
                fault <= 1'b1;
            end
        end
    end

    // Register file: contents survive reset, writes blocked while in reset
    always_ff @(posedge Clock) begin
        if (!Reset && regWe) begin
            regFile[dest[AddrWidth-1:0]] <= regWdata;
        end
    end

    // Return-address storage, indexed by the pre-push stack pointer
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            retStack[sp] <= irAddr + IP_WIDTH'(1);
        end
    end

    assign bus.oIP    = ip;
    assign bus.oLed   = led;
    assign bus.oFault = fault;
endmodule

// File: tb/tb_mini_alu_core.sv
// tb_mini_alu_core: self-checking bench for mini_alu_core (DATA_WIDTH 16,
// REG_COUNT 16, IP_WIDTH 8, STACK_DEPTH 2, LED_WIDTH 8) driven by a bench-side ROM.
module tb_mini_alu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mini_alu_core_if #(.IP_WIDTH(8), .LED_WIDTH(8)) bus ();

    logic [27:0] rom [256];
    assign bus.iInstruction = rom[bus.oIP];

    mini_alu_core #(
        .DATA_WIDTH (16),
        .REG_COUNT  (16),
        .IP_WIDTH   (8),
        .STACK_DEPTH(2),
        .LED_WIDTH  (8)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        flt;
        string       name;
    } vecT;

    typedef struct {
        logic [7:0] led;
        logic       flt;
        string      name;
    } expT;

    vecT vecs[12];
    expT sb[$];

    function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {4'h3, d, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 28'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset for two edges; returns on a negedge with Reset just released
    task automatic startRun();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitIp(input logic [7:0] addr, input int budget, input string name);
        int n = 0;
        while (bus.oIP !== addr && n < budget) begin
            tick();
            n++;
        end
        check(name, bus.oIP, addr);
    endtask

    initial begin
        expT e;
        int  taken;
        int  fallThru;
        logic [7:0] prevIp;
        int  expIp[8];

        vecs[0]  = '{4'h6, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, "sub_0_1"};
        vecs[1]  = '{4'h8, 16'h0001, 16'h0010, 16'h0000, 1'b0, "shl_by16"};
        vecs[2]  = '{4'h9, 16'h8000, 16'h000F, 16'h0001, 1'b0, "shr_by15"};
`ifdef MINIALU_MUL_EN
        vecs[3]  = '{4'h7, 16'h0100, 16'h0100, 16'h0000, 1'b0, "mul_wrap"};
        vecs[4]  = '{4'h7, 16'h0003, 16'h0005, 16'h000F, 1'b0, "mul_small"};
`else
        vecs[3]  = '{4'h7, 16'h0100, 16'h0100, 16'hBEEF, 1'b1, "mul_off_a"};
        vecs[4]  = '{4'h7, 16'h0003, 16'h0005, 16'hBEEF, 1'b1, "mul_off_b"};
`endif
        vecs[5]  = '{4'h4, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, "add_wrap"};
        vecs[6]  = '{4'h4, 16'h1234, 16'h4321, 16'h5555, 1'b0, "add_plain"};
        vecs[7]  = '{4'h8, 16'h00FF, 16'h0004, 16'h0FF0, 1'b0, "shl_by4"};
        vecs[8]  = '{4'h9, 16'h8000, 16'h0010, 16'h0000, 1'b0, "shr_by16"};
        vecs[9]  = '{4'h6, 16'h0005, 16'h0003, 16'h0002, 1'b0, "sub_plain"};
        vecs[10] = '{4'hD, 16'h0005, 16'h0003, 16'hBEEF, 1'b1, "illegal_d"};
        vecs[11] = '{4'hF, 16'h0005, 16'h0003, 16'hBEEF, 1'b1, "illegal_f"};

        // Table: R3 preset to 0xBEEF, op, then result byte selected by SHR onto the LEDs
        for (int i = 0; i < 12; i++) begin
            for (int sh = 0; sh <= 8; sh += 8) begin
                clearRom();
                rom[0] = sto(8'd1, vecs[i].a);
                rom[1] = sto(8'd2, vecs[i].b);
                rom[2] = sto(8'd3, 16'hBEEF);
                rom[3] = sto(8'd5, 16'(sh));
                rom[4] = ins(vecs[i].op, 8'd3, 8'd1, 8'd2);
                rom[5] = ins(4'h9, 8'd6, 8'd3, 8'd5);
                rom[6] = ins(4'h1, 8'd0, 8'd6, 8'd0);
                rom[7] = ins(4'h5, 8'd7, 8'd0, 8'd0);
                e.led  = 8'(vecs[i].res >> sh);
                e.flt  = vecs[i].flt;
                e.name = (sh == 0) ? {vecs[i].name, "_lo"} : {vecs[i].name, "_hi"};
                sb.push_back(e);
                startRun();
                waitIp(8'd7, 50, {e.name, "_halt"});
                repeat (4) tick();
                e = sb.pop_front();
                check({e.name, "_led"}, bus.oLed, e.led);
                check({e.name, "_fault"}, bus.oFault, e.flt);
            end
        end

        // Reset state after a run that left LED and fault set
        rst = 1'b1;
        tick();
        check("rst_ip", bus.oIP, 0);
        check("rst_led", bus.oLed, 0);
        check("rst_fault", bus.oFault, 0);

        // Cycle-exact LED timing of the basic add program
        clearRom();
        rom[0] = sto(8'd1, 16'h0005);
        rom[1] = sto(8'd2, 16'h0003);
        rom[2] = ins(4'h4, 8'd3, 8'd1, 8'd2);
        rom[3] = ins(4'h1, 8'd0, 8'd3, 8'd0);
        rom[4] = ins(4'h5, 8'd4, 8'd0, 8'd0);
        startRun();
        repeat (4) tick();
        check("add_led_cycle4", bus.oLed, 8'h00);
        tick();
        check("add_led_cycle5", bus.oLed, 8'h08);
        check("add_fault", bus.oFault, 0);

        // BLE loop: ten taken branches, each showing one squashed slot (5 -> 3)
        clearRom();
        rom[0] = sto(8'd1, 16'd0);
        rom[1] = sto(8'd2, 16'd1);
        rom[2] = sto(8'd4, 16'd10);
        rom[3] = ins(4'h4, 8'd1, 8'd1, 8'd2);
        rom[4] = ins(4'h2, 8'd3, 8'd1, 8'd4);
        rom[5] = ins(4'h1, 8'd0, 8'd1, 8'd0);
        rom[6] = ins(4'h5, 8'd6, 8'd0, 8'd0);
        startRun();
        taken = 0;
        fallThru = 0;
        for (int n = 0; n < 300 && bus.oIP != 8'd6; n++) begin
            prevIp = bus.oIP;
            tick();
            if (prevIp == 8'd5 && bus.oIP == 8'd3) taken++;
            if (prevIp == 8'd5 && bus.oIP == 8'd6) fallThru++;
        end
        check("loop_reach_end", bus.oIP, 8'd6);
        check("loop_taken", taken, 10);
        check("loop_fallthru", fallThru, 1);
        repeat (4) tick();
        check("loop_led", bus.oLed, 8'h0B);
        check("loop_fault", bus.oFault, 0);

        // Nested CALLs with a 2-entry stack, then RET on empty
        clearRom();
        rom[0]  = sto(8'd1, 16'h0011);
        rom[1]  = sto(8'd2, 16'h0022);
        rom[2]  = sto(8'd3, 16'h0033);
        rom[3]  = ins(4'hB, 8'd10, 8'd0, 8'd0);
        rom[4]  = ins(4'h1, 8'd0, 8'd3, 8'd0);
        rom[5]  = ins(4'hC, 8'd0, 8'd0, 8'd0);
        rom[6]  = sto(8'd7, 16'h0077);
        rom[7]  = ins(4'h1, 8'd0, 8'd7, 8'd0);
        rom[8]  = ins(4'h5, 8'd8, 8'd0, 8'd0);
        rom[10] = ins(4'hB, 8'd20, 8'd0, 8'd0);
        rom[11] = ins(4'h1, 8'd0, 8'd2, 8'd0);
        rom[12] = ins(4'hC, 8'd0, 8'd0, 8'd0);
        rom[20] = ins(4'hB, 8'd30, 8'd0, 8'd0);
        rom[21] = ins(4'h1, 8'd0, 8'd1, 8'd0);
        rom[22] = ins(4'hC, 8'd0, 8'd0, 8'd0);
        rom[30] = ins(4'h5, 8'd30, 8'd0, 8'd0);
        startRun();
        waitIp(8'd21, 50, "stk_reach_third_call");
        check("stk_fault_before", bus.oFault, 0);
        tick();
        check("stk_full_fallthru", bus.oIP, 8'd22);
        check("stk_overflow_fault", bus.oFault, 1);
        waitIp(8'd11, 20, "stk_ret_to_second");
        waitIp(8'd4, 20, "stk_ret_to_first");
        waitIp(8'd6, 20, "stk_reach_empty_ret");
        check("stk_led_first", bus.oLed, 8'h33);
        tick();
        check("stk_empty_ret_seq", bus.oIP, 8'd7);
        waitIp(8'd8, 20, "stk_halt");
        repeat (4) tick();
        check("stk_final_led", bus.oLed, 8'h77);
        check("stk_final_fault", bus.oFault, 1);

        // Reset in the execute cycle of a taken JMP, with one stack entry live
        clearRom();
        rom[0] = sto(8'd1, 16'h005A);
        rom[1] = ins(4'hB, 8'd4, 8'd0, 8'd0);
        rom[4] = ins(4'h1, 8'd0, 8'd1, 8'd0);
        rom[5] = ins(4'h5, 8'd9, 8'd0, 8'd0);
        rom[9] = ins(4'h5, 8'd9, 8'd0, 8'd0);
        startRun();
        waitIp(8'd6, 30, "jmprst_reach");
        check("jmprst_led_pre", bus.oLed, 8'h5A);
        rst = 1'b1;
        clearRom();
        rom[0] = ins(4'hC, 8'd0, 8'd0, 8'd0);
        rom[1] = sto(8'd3, 16'h003C);
        rom[2] = ins(4'h1, 8'd0, 8'd3, 8'd0);
        rom[3] = ins(4'h5, 8'd3, 8'd0, 8'd0);
        tick();
        rst = 1'b0;
        check("jmprst_ip", bus.oIP, 0);
        check("jmprst_led", bus.oLed, 0);
        check("jmprst_fault", bus.oFault, 0);
        tick();
        tick();
        check("jmprst_ret_seq", bus.oIP, 8'd2);
        check("jmprst_stack_empty", bus.oFault, 1);
        waitIp(8'd3, 20, "jmprst_halt");
        repeat (4) tick();
        check("jmprst_led_post", bus.oLed, 8'h3C);

        // BEQ unequal (no squash) then equal (taken)
        clearRom();
        rom[0]  = sto(8'd1, 16'h1234);
        rom[1]  = sto(8'd2, 16'h1234);
        rom[2]  = sto(8'd3, 16'h1235);
        rom[3]  = ins(4'hA, 8'd20, 8'd1, 8'd3);
        rom[4]  = ins(4'hA, 8'd10, 8'd1, 8'd2);
        rom[10] = ins(4'h1, 8'd0, 8'd1, 8'd0);
        rom[11] = ins(4'h5, 8'd11, 8'd0, 8'd0);
        rom[20] = ins(4'h5, 8'd20, 8'd0, 8'd0);
        expIp = '{1, 2, 3, 4, 5, 10, 11, 12};
        startRun();
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("beq_ip_%0d", k), bus.oIP, expIp[k]);
        end
        check("beq_led", bus.oLed, 8'h34);

        // IP wraps from 0xFF to 0x00
        clearRom();
        rom[0]   = ins(4'h5, 8'hFE, 8'd0, 8'd0);
        rom[254] = sto(8'd5, 16'h0055);
        rom[255] = ins(4'h1, 8'd0, 8'd5, 8'd0);
        startRun();
        tick();
        tick();
        check("wrap_jmp_target", bus.oIP, 8'hFE);
        tick();
        tick();
        check("wrap_ip_zero", bus.oIP, 8'h00);
        tick();
        check("wrap_led", bus.oLed, 8'h55);

        // Register addresses alias modulo REG_COUNT
        clearRom();
        rom[0] = sto(8'h13, 16'h00C7);
        rom[1] = sto(8'd4, 16'h0000);
        rom[2] = ins(4'h1, 8'd0, 8'd4, 8'd0);
        rom[3] = ins(4'h1, 8'd0, 8'h23, 8'd0);
        rom[4] = ins(4'h5, 8'd4, 8'd0, 8'd0);
        startRun();
        waitIp(8'd4, 20, "alias_halt");
        repeat (4) tick();
        check("alias_led", bus.oLed, 8'hC7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
